spi_word_tx: RTL and testbench
==============================

Name: spi_word_tx

Overview:
- Transmit-side counterpart of the controller's 64-bit SPI receive path.
- Accepts 64-bit words (sphere records, status or telemetry) from the raytracing controller and queues them in a small word FIFO.
- Serializes each word into bytes for the SPI slave byte engine over a tran_dv/tran_byte/tran_ack handshake.
- Raises tran_interrupt so the MCU knows to clock the bytes out.

Parameters:
- WORD_DEPTH, 2: word FIFO depth; power of two, at least 2.
- MSB_FIRST, 1: 1 sends byte [63:56] first; 0 sends byte [7:0] first.
- CNT_B, 16: width of the words_sent counter.

Ports:
- CLK100MHZ  in  1  system clock; all logic is on the rising edge.
- ck_rst  in  1  reset; synchronous, active-high.
- word_valid  in  1  producer has a word on word_data.
- word_data  in  64  word to transmit.
- word_ready  out  1  FIFO can accept a word this cycle.
- tran_dv  out  1  tran_byte is valid for the SPI byte engine.
- tran_byte  out  8  current byte.
- tran_ack  in  1  SPI engine has taken tran_byte this cycle.
- tran_interrupt  out  1  a word is in flight to the MCU.
- busy  out  1  FSM is not IDLE, or the FIFO is not empty.
- words_sent  out  CNT_B  count of fully transmitted words.

Behaviour:
- Reset values: word_ready=1, tran_dv=0, tran_byte=0, tran_interrupt=0, busy=0, words_sent=0.
- Reset clears the FIFO pointers and count and forces IDLE.
- Reset mid-word drops the partial word and all queued words. No further bytes are presented.
- Reset has priority over every other event in the same cycle.
- FIFO push occurs when word_valid && word_ready.
- word_ready = (count < WORD_DEPTH), decoded from the registered count. It is a combinational output of registers only; there is no combinational path from word_valid.
- Push and pop in the same cycle leave count unchanged. With the FIFO full, push cannot occur because word_ready=0.
- FSM states:
  - IDLE: if the FIFO is not empty, pop the head word into a 64-bit shift register, set byte_idx=0, go to LOAD.
  - LOAD: one cycle. Drive tran_byte from the shift register (top byte if MSB_FIRST, else low byte). Set tran_dv=1 and tran_interrupt=1. Go to SEND.
  - SEND: hold tran_dv and tran_byte stable until tran_ack=1.
    - On ack, if byte_idx < 7: shift by 8, increment byte_idx, and present the next byte in the next cycle with tran_dv kept high (no bubble).
    - On ack of the last byte: tran_dv=0, go to DONE (or CHK when CHECKSUM_EN is defined).
  - DONE: one cycle. tran_interrupt=0, words_sent increments, go to IDLE.
- tran_ack while tran_dv=0 is ignored.
- Timing from an idle block with an empty FIFO:
  - Word accepted at cycle N; it is popped at N+1 (IDLE→LOAD).
  - tran_dv=1 at N+2, with the first byte visible.
- Word-to-word: tran_interrupt is low for at least 2 cycles (DONE, IDLE) between words, so the MCU sees a falling edge per word.
- Throughput: with tran_ack tied high, a word takes 8 data cycles plus 3 overhead cycles.
- words_sent wraps from 2^CNT_B−1 to 0 without saturating.
- busy = (state != IDLE) || (count != 0).

Optional Feature:
- Macro: SPI_WORD_TX_CHECKSUM_EN.
- Defined:
  - An 8-bit running XOR of all 8 data bytes is accumulated as each byte is acked.
  - After the last data byte ack, state CHK presents the XOR as a 9th byte, with tran_dv kept high and no bubble, waiting for tran_ack.
  - On that ack, go to DONE.
  - tran_interrupt stays high through CHK.
- Not defined: no CHK state and no accumulator logic. Exactly 8 bytes per word.

Test Plan:
1. Reset then idle: hold ck_rst=1 for 3 cycles, release → word_ready=1, tran_dv=0, tran_interrupt=0, busy=0, words_sent=0.
2. Single word, MSB_FIRST=1, tran_ack tied high: push 64'h0123_4567_89AB_CDEF at cycle N → tran_dv rises at N+2. Bytes 01,23,45,67,89,AB,CD,EF appear on consecutive cycles. tran_interrupt falls the cycle after the EF ack. words_sent=1.
3. Backpressure and fill: tran_ack=0, push 3 words back-to-back → the first two are accepted and word_ready=0 for the third. tran_byte stays at 8'h01 and stable. Pulse tran_ack once → tran_byte=8'h23 the next cycle.
4. MSB_FIRST=0 with CHECKSUM_EN defined: push 64'h0000_0000_0000_00FF → bytes FF,00,00,00,00,00,00,00 then checksum FF.
5. Reset mid-word: assert ck_rst after the 3rd byte ack with a second word queued → next cycle tran_dv=0 and the FIFO is empty. No remaining bytes of either word are ever presented.
6. Counter wrap: CNT_B=2, send 5 words → words_sent sequence 1,2,3,0,1. tran_interrupt is low for at least 2 cycles between each word.

Source files
------------

// File: rtl/spi_word_tx.sv
// Queues 64-bit words and serializes them into bytes for the SPI slave byte engine.
// Define SPI_WORD_TX_CHECKSUM_EN to append an XOR checksum byte after each word.
module spi_word_tx #(
  parameter int WORD_DEPTH = 2,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int CNT_B      = 16
) (
  input  logic             CLK100MHZ,
  input  logic             ck_rst,
  input  logic             word_valid,
  input  logic [63:0]      word_data,
  output logic             word_ready,
  output logic             tran_dv,
  output logic [7:0]       tran_byte,
  input  logic             tran_ack,
  output logic             tran_interrupt,
  output logic             busy,
  output logic [CNT_B-1:0] words_sent
);
  localparam int PW = $clog2(WORD_DEPTH);
  localparam int CW = PW + 1;

`ifdef SPI_WORD_TX_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LOAD, SEND, CHK, DONE} state_e;
`else
  typedef enum logic [2:0] {IDLE, LOAD, SEND, DONE} state_e;
`endif

  state_e            state_q, state_d;
  logic [63:0]       mem_q [WORD_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [63:0]       shreg_q, shreg_d;
  logic [2:0]        idx_q, idx_d;
  logic              dv_q, dv_d, int_q, int_d;
  logic [7:0]        byte_q, byte_d;
  logic [CNT_B-1:0]  ws_q, ws_d;
  logic              push, pop, ack;
`ifdef SPI_WORD_TX_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  function automatic logic [7:0] head_byte(input logic [63:0] w);
    return MSB_FIRST ? w[63:56] : w[7:0];
  endfunction

  function automatic logic [63:0] shift_word(input logic [63:0] w);
    return MSB_FIRST ? (w << 8) : (w >> 8);
  endfunction

  assign word_ready     = (count_q < CW'(WORD_DEPTH));
  assign push           = word_valid && word_ready;
  assign ack            = tran_ack && dv_q;
  assign tran_dv        = dv_q;
  assign tran_byte      = byte_q;
  assign tran_interrupt = int_q;
  assign words_sent     = ws_q;
  assign busy           = (state_q != IDLE) || (count_q != '0);

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    dv_d    = dv_q;
    byte_d  = byte_q;
    int_d   = int_q;
    ws_d    = ws_q;
    pop     = 1'b0;
`ifdef SPI_WORD_TX_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    unique case (state_q)
      IDLE: if (count_q != '0) begin
        pop     = 1'b1;
        shreg_d = mem_q[rd_ptr_q];
        idx_d   = 3'd0;
`ifdef SPI_WORD_TX_CHECKSUM_EN
        csum_d  = 8'h00;
`endif
        state_d = LOAD;
      end
      LOAD: begin
        byte_d  = head_byte(shreg_q);
        dv_d    = 1'b1;
        int_d   = 1'b1;
        state_d = SEND;
      end
      SEND: if (ack) begin
`ifdef SPI_WORD_TX_CHECKSUM_EN
        csum_d = csum_q ^ byte_q;
`endif
        if (idx_q != 3'd7) begin
          // Next byte is registered straight from the shifted word, so tran_dv never dips.
          shreg_d = shift_word(shreg_q);
          byte_d  = head_byte(shift_word(shreg_q));
          idx_d   = idx_q + 3'd1;
        end else begin
`ifdef SPI_WORD_TX_CHECKSUM_EN
          byte_d  = csum_q ^ byte_q;
          state_d = CHK;
`else
          dv_d    = 1'b0;
          int_d   = 1'b0;
          state_d = DONE;
`endif
        end
      end
`ifdef SPI_WORD_TX_CHECKSUM_EN
      CHK: if (ack) begin
        dv_d    = 1'b0;
        int_d   = 1'b0;
        state_d = DONE;
      end
`endif
      DONE: begin
        int_d   = 1'b0;
        ws_d    = ws_q + CNT_B'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (push) mem_q[wr_ptr_q] <= word_data;
  end

  always_ff @(posedge CLK100MHZ) begin
    if (ck_rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      shreg_q  <= '0;
      idx_q    <= '0;
      dv_q     <= 1'b0;
      byte_q   <= '0;
      int_q    <= 1'b0;
      ws_q     <= '0;
`ifdef SPI_WORD_TX_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      shreg_q  <= shreg_d;
      idx_q    <= idx_d;
      dv_q     <= dv_d;
      byte_q   <= byte_d;
      int_q    <= int_d;
      ws_q     <= ws_d;
`ifdef SPI_WORD_TX_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end
endmodule

// File: tb/tb_spi_word_tx.sv
// Directed bench for spi_word_tx: one MSB-first/16-bit-counter instance and one
// LSB-first/2-bit-counter instance share clock and reset.
module tb_spi_word_tx;
  logic        clk = 1'b0;
  logic        rst;
  logic        wv1, wr1, dv1, ack1, int1, busy1;
  logic [63:0] wd1;
  logic [7:0]  tb1;
  logic [15:0] ws1;
  logic        wv2, wr2, dv2, ack2, int2, busy2;
  logic [63:0] wd2;
  logic [7:0]  tb2;
  logic [1:0]  ws2;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  spi_word_tx u_dut1 (
    .CLK100MHZ(clk), .ck_rst(rst), .word_valid(wv1), .word_data(wd1),
    .word_ready(wr1), .tran_dv(dv1), .tran_byte(tb1), .tran_ack(ack1),
    .tran_interrupt(int1), .busy(busy1), .words_sent(ws1)
  );

  spi_word_tx #(.WORD_DEPTH(2), .MSB_FIRST(1'b0), .CNT_B(2)) u_dut2 (
    .CLK100MHZ(clk), .ck_rst(rst), .word_valid(wv2), .word_data(wd2),
    .word_ready(wr2), .tran_dv(dv2), .tran_byte(tb2), .tran_ack(ack2),
    .tran_interrupt(int2), .busy(busy2), .words_sent(ws2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_b [8];
    logic [1:0] ws_seq [4];
    int k, low_run, bad;
    logic seen_hi, prev_int;
    logic [1:0] prev_ws;

    rst = 1'b1; wv1 = 0; wd1 = '0; ack1 = 0; wv2 = 0; wd2 = '0; ack2 = 0;

    // 1: reset then idle
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_ready", wr1, 1);
    chk("rst_dv", dv1, 0);
    chk("rst_int", int1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_ws", ws1, 0);
    chk("rst_byte", tb1, 0);

    // 2: single word, MSB first, ack tied high
    exp_b = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    ack1 = 1'b1;
    wv1 = 1'b1; wd1 = 64'h0123_4567_89AB_CDEF;
    step();                       // push edge N
    wv1 = 1'b0;
    chk("t2_dv_n1", dv1, 0);
    step();                       // N+1: pop
    chk("t2_dv_n1b", dv1, 0);
    step();                       // N+2
    chk("t2_dv_n2", dv1, 1);
    chk("t2_int", int1, 1);
    chk("t2_b0", tb1, exp_b[0]);
    for (int i = 1; i < 8; i++) begin
      step();
      chk($sformatf("t2_b%0d", i), tb1, exp_b[i]);
      chk($sformatf("t2_dv%0d", i), dv1, 1);
    end
    step();
    chk("t2_dv_end", dv1, 0);
    chk("t2_int_fall", int1, 0);
    step();
    chk("t2_ws", ws1, 1);
    chk("t2_busy", busy1, 0);

    // 3: backpressure and fill
    ack1 = 1'b0;
    wv1 = 1'b1; wd1 = 64'h0123_4567_89AB_CDEF;
    step();
    wv1 = 1'b0;
    step(); step();
    chk("t3_dv", dv1, 1);
    chk("t3_b0", tb1, 8'h01);
    wv1 = 1'b1; wd1 = 64'hA0A1_A2A3_A4A5_A6A7;
    chk("t3_rdy_a", wr1, 1);
    step();
    wd1 = 64'hB0B1_B2B3_B4B5_B6B7;
    chk("t3_rdy_b", wr1, 1);
    step();
    wd1 = 64'hC0C1_C2C3_C4C5_C6C7;
    chk("t3_rdy_c", wr1, 0);
    step();
    chk("t3_rdy_c2", wr1, 0);
    chk("t3_hold", tb1, 8'h01);
    chk("t3_hold_dv", dv1, 1);
    wv1 = 1'b0;
    ack1 = 1'b1;
    step();
    ack1 = 1'b0;
    chk("t3_next", tb1, 8'h23);
    step();
    chk("t3_next_hold", tb1, 8'h23);
    ack1 = 1'b1;
    k = 0;
    while (busy1 && k < 200) begin step(); k++; end
    chk("t3_drain_to", busy1, 0);
    chk("t3_ws", ws1, 4);

    // 4: LSB first (checksum byte when built with the checksum feature)
    ack2 = 1'b1;
    wv2 = 1'b1; wd2 = 64'h0000_0000_0000_00FF;
    step();
    wv2 = 1'b0;
    step(); step();
    chk("t4_b0", tb2, 8'hFF);
    chk("t4_dv0", dv2, 1);
    for (int i = 1; i < 8; i++) begin
      step();
      chk($sformatf("t4_b%0d", i), tb2, 8'h00);
    end
    step();
`ifdef SPI_WORD_TX_CHECKSUM_EN
    chk("t4_csum_dv", dv2, 1);
    chk("t4_csum", tb2, 8'hFF);
    chk("t4_csum_int", int2, 1);
    step();
`endif
    chk("t4_dv_end", dv2, 0);
    step();
    chk("t4_ws", ws2, 1);

    // 6: counter wrap on the 2-bit instance, plus interrupt gap per word
    ws_seq = '{2'd2, 2'd3, 2'd0, 2'd1};
    wv2 = 1'b1; wd2 = 64'h8877_6655_4433_2211;
    k = 0; low_run = 0; seen_hi = 1'b0; prev_int = int2; prev_ws = ws2;
    for (int c = 0; c < 300 && k < 4; c++) begin
      step();
      if (int2 && !prev_int && seen_hi) chk("t6_int_gap", (low_run >= 2), 1);
      if (int2) begin seen_hi = 1'b1; low_run = 0; end
      else low_run++;
      if (ws2 != prev_ws) begin
        chk($sformatf("t6_ws%0d", k), ws2, ws_seq[k]);
        k++;
      end
      prev_int = int2; prev_ws = ws2;
    end
    chk("t6_done", k, 4);
    wv2 = 1'b0;

    // 5: reset mid-word with a second word queued
    ack1 = 1'b1;
    wv1 = 1'b1; wd1 = 64'h1122_3344_5566_7788;
    step();                      // push X
    wd1 = 64'h99AA_BBCC_DDEE_FF00;
    step();                      // push Y, pop X
    wv1 = 1'b0;
    step(); step(); step(); step();
    chk("t5_byte3", tb1, 8'h44);
    chk("t5_queued", busy1, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_dv", dv1, 0);
    chk("t5_busy", busy1, 0);
    chk("t5_ready", wr1, 1);
    chk("t5_int", int1, 0);
    chk("t5_ws", ws1, 0);
    bad = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (dv1 || busy1) bad++;
    end
    chk("t5_no_bytes", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
